// File: rtl/fifo_uart_tx_pkg.sv
// Shared types and helpers for the FIFO-fed UART transmitter and its baud generator.
package fifo_uart_tx_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_POP   = 3'd1,
    S_LOAD  = 3'd2,
    S_START = 3'd3,
    S_DATA  = 3'd4,
    S_STOP  = 3'd5
  } state_t;

  localparam int DEFAULT_CLKS_PER_BIT = 16;

  // Bits needed to hold values 0..value-1 (minimum 1).
  function automatic int clog2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_uart_tx_baud_tick_gen.sv
// Free-running bit-period counter with synchronous clear; o_tick marks the last clk of each bit.
module fifo_uart_tx_baud_tick_gen
  import fifo_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  output logic o_tick
);

  localparam int CW = clog2(CLKS_PER_BIT);

  logic [CW-1:0] r_count;

  assign o_tick = !i_clear && (r_count == CW'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clear || o_tick) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CW'(1);
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops words from a synchronous FIFO and serialises each one LSB-first as a start/data/stop frame.
module fifo_uart_tx
  import fifo_uart_tx_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int STOP_BITS    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tx_enable,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_dout,
  output logic             fifo_rd_en,
  output logic             tx,
  output logic             busy,
  output logic             frame_done,
  output state_t           dbg_state
);

  localparam int IW = clog2(WIDTH + 1);

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] w_shift_next;
  logic [IW-1:0]    r_bit_idx;
  logic [IW-1:0]    w_bit_idx_next;
  logic             r_tx;
  logic             w_tx_next;
  logic             w_tick;
  logic             w_baud_clear;
  logic             w_start_ok;
  logic             w_frame_done;

  // FIFO side: fifo_rd_en is a one-cycle pop strobe, only raised when fifo_empty
  // was low; the popped word is taken from fifo_dout on the following cycle (LOAD).
  assign w_start_ok   = tx_enable && !fifo_empty;
  assign w_baud_clear = (r_state == S_IDLE) || (r_state == S_POP) || (r_state == S_LOAD);

  fifo_uart_tx_baud_tick_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_baud_clear),
    .o_tick  (w_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_bit_idx <= '0;
      r_tx      <= 1'b1;
    end else begin
      r_state   <= w_next_state;
      r_shift   <= w_shift_next;
      r_bit_idx <= w_bit_idx_next;
      r_tx      <= w_tx_next;
    end
  end

  always_comb begin
    w_next_state   = r_state;
    w_shift_next   = r_shift;
    w_bit_idx_next = r_bit_idx;
    w_frame_done   = 1'b0;
    w_tx_next      = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (w_start_ok) w_next_state = S_POP;
      end
      S_POP: begin
        w_next_state = S_LOAD;
      end
      S_LOAD: begin
        w_shift_next   = fifo_dout;
        w_bit_idx_next = '0;
        w_next_state   = S_START;
      end
      S_START: begin
        if (w_tick) w_next_state = S_DATA;
      end
      S_DATA: begin
        if (w_tick) begin
          w_shift_next = r_shift >> 1;
          if (r_bit_idx == IW'(WIDTH - 1)) begin
            w_bit_idx_next = '0;
            w_next_state   = S_STOP;
          end else begin
            w_bit_idx_next = r_bit_idx + IW'(1);
          end
        end
      end
      S_STOP: begin
        // The bit index is reused to count stop bits.
        if (w_tick) begin
          if (r_bit_idx == IW'(STOP_BITS - 1)) begin
            w_frame_done   = 1'b1;
            w_bit_idx_next = '0;
            w_next_state   = w_start_ok ? S_POP : S_IDLE;
          end else begin
            w_bit_idx_next = r_bit_idx + IW'(1);
          end
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
    // The line level is derived from the upcoming state so tx leaves a flop aligned with r_state.
    case (w_next_state)
      S_START: w_tx_next = 1'b0;
      S_DATA:  w_tx_next = w_shift_next[0];
      default: w_tx_next = 1'b1;
    endcase
  end

  assign fifo_rd_en = (r_state == S_POP);
  assign busy       = (r_state != S_IDLE);
  assign frame_done = w_frame_done;
  assign tx         = r_tx;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed and random frames against two instances (one and two stop bits) with a FIFO model and byte scoreboard.
module tb_fifo_uart_tx;
  import fifo_uart_tx_pkg::*;

  localparam int CPB = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tx_enable = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog expired");
  end

  // ---------------- DUTs and FIFO models ----------------
  logic       fifo1_empty = 1'b1;
  logic       fifo2_empty = 1'b1;
  logic [7:0] fifo1_dout = '0;
  logic [7:0] fifo2_dout = '0;
  logic       under1 = 1'b0;
  logic       under2 = 1'b0;
  logic [7:0] fifo1_q[$];
  logic [7:0] fifo2_q[$];
  logic       rd1, tx1, busy1, fd1;
  logic       rd2, tx2, busy2, fd2;
  state_t     st1, st2;

  fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut1 (
    .clk(clk), .rst(rst), .tx_enable(tx_enable), .fifo_empty(fifo1_empty),
    .fifo_dout(fifo1_dout), .fifo_rd_en(rd1), .tx(tx1), .busy(busy1),
    .frame_done(fd1), .dbg_state(st1)
  );

  fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst(rst), .tx_enable(tx_enable), .fifo_empty(fifo2_empty),
    .fifo_dout(fifo2_dout), .fifo_rd_en(rd2), .tx(tx2), .busy(busy2),
    .frame_done(fd2), .dbg_state(st2)
  );

  // Synchronous FIFO: data appears the cycle after a pop, empty flag updates one cycle late.
  always @(posedge clk) begin
    if (rd1) begin
      if (fifo1_q.size() == 0) under1 <= 1'b1;
      else fifo1_dout <= fifo1_q.pop_front();
    end
    fifo1_empty <= (fifo1_q.size() == 0);
  end

  always @(posedge clk) begin
    if (rd2) begin
      if (fifo2_q.size() == 0) under2 <= 1'b1;
      else fifo2_dout <= fifo2_q.pop_front();
    end
    fifo2_empty <= (fifo2_q.size() == 0);
  end

  // Observed outputs of the selected instance.
  logic   sel = 1'b0;
  logic   m_tx, m_busy, m_rd, m_fd;
  state_t m_state;
  always_comb begin
    m_tx    = sel ? tx2   : tx1;
    m_busy  = sel ? busy2 : busy1;
    m_rd    = sel ? rd2   : rd1;
    m_fd    = sel ? fd2   : fd1;
    m_state = sel ? st2   : st1;
  end

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic push(input logic s, input logic [7:0] b);
    if (s) fifo2_q.push_back(b);
    else   fifo1_q.push_back(b);
    exp_q.push_back(b);
  endtask

  task automatic wait_rd(input string tag, input int budget);
    int n;
    n = 0;
    while (m_rd !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'd0, m_rd}, 32'd1);
  endtask

  task automatic count_rd(input int ncyc, output int cnt, output int tx_low);
    cnt = 0;
    tx_low = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (m_rd === 1'b1) cnt++;
      if (m_tx !== 1'b1) tx_low++;
    end
  endtask

  // Called on the negedge showing the pop strobe; walks LOAD plus the whole frame.
  task automatic check_frame(input logic [7:0] b, input int sb, input int drop_at);
    logic [11:0] bits;
    int nb;
    bits = {2'b11, b, 1'b0};
    nb = (1 + 8 + sb) * CPB;
    @(negedge clk);
    chk("load_rd_low", {31'd0, m_rd}, 32'd0);
    chk("load_tx_high", {31'd0, m_tx}, 32'd1);
    chk("load_busy", {31'd0, m_busy}, 32'd1);
    for (int c = 0; c < nb; c++) begin
      @(negedge clk);
      chk($sformatf("tx_b%0h_c%0d", b, c), {31'd0, m_tx}, {31'd0, bits[c / CPB]});
      chk($sformatf("frame_done_c%0d", c), {31'd0, m_fd}, {31'd0, (c == nb - 1)});
      chk("busy_in_frame", {31'd0, m_busy}, 32'd1);
      chk("no_rd_in_frame", {31'd0, m_rd}, 32'd0);
      if (c == drop_at) tx_enable = 1'b0;
    end
  endtask

  // Runs n queued frames back to back and checks pop spacing and the return to idle.
  task automatic run_burst(input int n, input int sb);
    int t0;
    logic [7:0] b;
    wait_rd("burst_first_pop", 6);
    for (int i = 0; i < n; i++) begin
      t0 = cyc;
      b = exp_q.pop_front();
      check_frame(b, sb, -1);
      @(negedge clk);
      if (i < n - 1) begin
        chk("b2b_pop", {31'd0, m_rd}, 32'd1);
        chk("b2b_period", cyc - t0, (1 + 8 + sb) * CPB + 2);
      end else begin
        chk("end_no_pop", {31'd0, m_rd}, 32'd0);
        chk("end_busy_low", {31'd0, m_busy}, 32'd0);
        chk("end_state_idle", {29'd0, m_state}, {29'd0, S_IDLE});
      end
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int cnt, txl, gap, nr;
    logic [7:0] b5a;
    logic [11:0] bits5a;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_tx", {31'd0, m_tx}, 32'd1);
    chk("rst_busy", {31'd0, m_busy}, 32'd0);
    chk("rst_rd", {31'd0, m_rd}, 32'd0);
    chk("rst_fd", {31'd0, m_fd}, 32'd0);
    chk("rst_state", {29'd0, m_state}, {29'd0, S_IDLE});
    rst = 1'b0;

    // 1: empty FIFO, enabled -> nothing happens
    count_rd(100, cnt, txl);
    chk("idle_no_pop", cnt, 0);
    chk("idle_tx_high", txl, 0);
    chk("idle_busy", {31'd0, m_busy}, 32'd0);

    // 2: single 0xA5 frame
    push(1'b0, 8'hA5);
    run_burst(1, 1);

    // 3: three back-to-back words
    push(1'b0, 8'h01);
    push(1'b0, 8'hFF);
    push(1'b0, 8'h3C);
    run_burst(3, 1);

    // 4: enable gating, drop mid-DATA
    tx_enable = 1'b0;
    push(1'b0, 8'h96);
    push(1'b0, 8'h5A);
    count_rd(20, cnt, txl);
    chk("disabled_no_pop", cnt, 0);
    tx_enable = 1'b1;
    @(negedge clk);
    chk("pop_1clk_after_enable", {31'd0, m_rd}, 32'd1);
    check_frame(exp_q.pop_front(), 1, 4 * CPB);
    @(negedge clk);
    chk("drop_no_pop", {31'd0, m_rd}, 32'd0);
    chk("drop_idle_busy", {31'd0, m_busy}, 32'd0);
    count_rd(30, cnt, txl);
    chk("drop_stays_idle", cnt, 0);

    // 5: async reset during DATA bit 3 of 0x5A
    push(1'b0, 8'h3E);
    tx_enable = 1'b1;
    wait_rd("pop_5a", 6);
    b5a = exp_q.pop_front();
    bits5a = {2'b11, b5a, 1'b0};
    @(negedge clk);
    for (int c = 0; c <= 4 * CPB + CPB / 2; c++) begin
      @(negedge clk);
      chk($sformatf("tx5a_c%0d", c), {31'd0, m_tx}, {31'd0, bits5a[c / CPB]});
    end
    chk("mid_bit3_busy", {31'd0, m_busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_tx", {31'd0, m_tx}, 32'd1);
    chk("async_rst_busy", {31'd0, m_busy}, 32'd0);
    chk("async_rst_state", {29'd0, m_state}, {29'd0, S_IDLE});
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run_burst(1, 1);

    // Random words with a random idle gap
    gap = $urandom_range(1, 40);
    count_rd(gap, cnt, txl);
    chk("rand_gap_no_pop", cnt, 0);
    nr = $urandom_range(2, 4);
    for (int i = 0; i < nr; i++) push(1'b0, 8'($urandom_range(0, 255)));
    run_burst(nr, 1);

    // 6: two stop bits, 0x00 -> 176-clk frame
    sel = 1'b1;
    chk("sb2_idle", {31'd0, m_busy}, 32'd0);
    push(1'b1, 8'h00);
    run_burst(1, 2);
    push(1'b1, 8'($urandom_range(0, 255)));
    run_burst(1, 2);

    chk("dut1_no_underflow", {31'd0, under1}, 32'd0);
    chk("dut2_no_underflow", {31'd0, under2}, 32'd0);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
Read-side consumer of the team's synchronous FIFO. It pops one word at a time when the FIFO is non-empty and the downstream link is enabled. Each word is serialized LSB-first as an 8N1-style UART frame on a single output line. It sits between the FIFO's dout/empty/rd_en interface and the board TX pin.

Parameters:
WIDTH, 8, data word width; must match the FIFO WIDTH.
CLKS_PER_BIT, 16, clk cycles per serial bit; must be >= 2.
STOP_BITS, 1, number of stop bits; legal values are 1 and 2.

Ports:
clk  input  1  system clock; all logic is on the rising edge.
rst  input  1  asynchronous, active-high reset.
tx_enable  input  1  downstream ready. When low, no new pop is started; a frame already in progress completes.
fifo_empty  input  1  FIFO empty flag.
fifo_dout  input  WIDTH  FIFO read data; valid on the cycle after a fifo_rd_en pulse.
fifo_rd_en  output  1  single-cycle pop strobe to the FIFO.
tx  output  1  serial line; idles high.
busy  output  1  high from the pop strobe until the last stop bit ends.
frame_done  output  1  one-cycle pulse on the final clk of the last stop bit.

Behaviour:
- Reset (asynchronous, any state, including mid-frame): state=IDLE, tx=1, fifo_rd_en=0, busy=0, frame_done=0, baud counter=0, bit index=0, shift register=0. Release: the first transition is evaluated on the first clk edge with rst low.
- FSM states: IDLE, POP, LOAD, START, DATA, STOP.
  - IDLE: if tx_enable && !fifo_empty, go to POP. Otherwise stay, with tx=1.
  - POP: fifo_rd_en=1 for exactly this one cycle; busy=1. Next state is LOAD.
  - LOAD: capture fifo_dout into the shift register (one-cycle FIFO read latency). Next state is START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: tx=shift[0]. After each CLKS_PER_BIT cycles, shift right and increment the bit index. After WIDTH bits, go to STOP.
  - STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles. frame_done is pulsed on the last cycle. Then:
    - if tx_enable && !fifo_empty, go directly to POP (back-to-back frames, no idle bit);
    - otherwise go to IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary. Width is clog2(CLKS_PER_BIT).
- Timing:
  - Latency from fifo_rd_en to the tx falling edge is 2 clk.
  - Frame length is (1+WIDTH+STOP_BITS)*CLKS_PER_BIT clk.
  - Back-to-back frame period is that length plus 2 clk (POP, LOAD).
- fifo_rd_en is never asserted while fifo_empty=1. It is never asserted twice within 2 cycles, which covers the FIFO's one-cycle flag update lag.
- tx_enable dropping mid-frame has no effect on the current frame. It only blocks the next pop.
- fifo_empty rising mid-frame is ignored; it is sampled only in IDLE and at the end of STOP.
- tx is a registered output and is glitch-free.

Decomposition:
- Shared package: FSM state enum (IDLE, POP, LOAD, START, DATA, STOP), a clog2 helper, default baud constant.
- One natural sub-module: baud_tick_gen (CLKS_PER_BIT counter with a clear input and a one-cycle tick output). It is reusable by the future RX block.

Test Plan:
1. Reset with FIFO empty and tx_enable=1 -> tx=1, busy=0, fifo_rd_en never pulses over 100 clk.
2. FIFO holds 0xA5, CLKS_PER_BIT=16 -> one rd_en pulse. tx=0 for 16 clk, then bits 1,0,1,0,0,1,0,1 at 16 clk each, then 16 clk high. frame_done pulses at clk 160 after LOAD; busy falls afterwards.
3. FIFO holds 0x01, 0xFF, 0x3C with tx_enable=1 -> exactly 3 rd_en pulses, spaced 162 clk apart. Decoded bytes are 0x01, 0xFF, 0x3C. Returns to IDLE with fifo_empty=1.
4. tx_enable=0 with FIFO non-empty -> no pop. Raise tx_enable -> rd_en 1 clk later. Drop tx_enable mid-DATA -> current frame completes and no further pop occurs.
5. Assert rst during DATA bit 3 of 0x5A -> tx=1 and busy=0 immediately, without waiting for a clk edge. After release, the next pop sends the next FIFO word, not the remainder of 0x5A.
6. STOP_BITS=2, byte 0x00 -> stop interval is 32 clk high; total frame is 176 clk.
